// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: ALUCon codes, mul/div FSM
// state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_DIV = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b0111;
  localparam logic [3:0] ALU_STA = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / restoring divide engine, one bit per cycle on
// magnitudes, with sign fixup applied in the final state.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_RUN   | one shift-add / shift-subtract step per cycle, count_q down to 1
// ST_FIXUP | apply signs, write hi/lo, done_o high this cycle
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] fin_lo_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             op_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi_d;
  logic [WIDTH-1:0]   step_lo_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi_d;
  logic [WIDTH-1:0]   fin_lo_d;

  assign a_abs = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_abs = b_i[WIDTH-1] ? -b_i : b_i;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_trial} - {2'b00, opnd_q};
    step_hi_d = mul_sum[WIDTH:1];
    step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    if (op_div_q) begin
      // Restoring step: keep the trial remainder only when it went non-negative.
      if (div_diff[WIDTH+1]) begin
        step_hi_d = div_trial[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi_d = div_diff[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    fin_hi_d = '0;
    fin_lo_d = '0;
    if (op_div_q) begin
      fin_hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
      if (dbz_q) fin_lo_d = '1;
      else       fin_lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
    end else begin
      {fin_hi_d, fin_lo_d} = neg_res_q ? -prod : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_RUN;
            count_q   <= CW'(WIDTH);
            op_div_q  <= op_div_i;
            opnd_q    <= op_div_i ? b_abs : a_abs;
            acc_lo_q  <= op_div_i ? a_abs : b_abs;
            acc_hi_q  <= '0;
            neg_res_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_rem_q <= a_i[WIDTH-1];
            dbz_q     <= op_div_i && (b_i == '0);
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            count_q  <= count_q - 1'b1;
            if (count_q == CW'(1)) state_q <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          state_q <= ST_IDLE;
          if (!flush_i) begin
            hi_q <= fin_hi_d;
            lo_q <= fin_lo_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_FIXUP) && !flush_i;
  assign fin_lo_o = fin_lo_d;
  assign dbz_o    = dbz_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops with registered outputs, plus the
// ready/busy handshake and flush around the iterative mul/div engine.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucon,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic             md_dbz;
  logic [WIDTH-1:0] md_fin_lo;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_res_d;
  logic             sc_ovf_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             dbz_q;

  // Flush wins over a same-cycle accept, so a flushed op never issues.
  assign accept   = in_valid && in_ready && !flush;
  assign md_start = accept && is_muldiv(alucon);
  assign in_ready = !md_busy;
  assign busy     = md_busy;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    sc_res_d = '0;
    sc_ovf_d = 1'b0;
    case (alucon)
      ALU_ADD, ALU_STA: begin
        sc_res_d = sum;
        sc_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res_d = diff;
        sc_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: sc_res_d = a & b;
      ALU_OR:  sc_res_d = a | b;
      ALU_NOR: sc_res_d = ~(a | b);
      ALU_SLT: sc_res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: sc_res_d = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .op_div_i (alucon == ALU_DIV),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .fin_lo_o (md_fin_lo),
    .dbz_o    (md_dbz),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  // md_done and a single-cycle accept are exclusive: accept needs !busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (md_done) begin
        out_valid_q <= 1'b1;
        result_q    <= md_fin_lo;
        zero_q      <= (md_fin_lo == '0);
        overflow_q  <= 1'b0;
        dbz_q       <= md_dbz;
      end else if (accept && !is_muldiv(alucon)) begin
        out_valid_q <= 1'b1;
        result_q    <= sc_res_d;
        zero_q      <= (sc_res_d == '0);
        overflow_q  <= sc_ovf_d;
        dbz_q       <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed and randomized ops compared
// against a wide-integer reference model.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alucon;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alucon(alucon), .a(a), .b(b), .flush(flush), .busy(busy),
    .out_valid(out_valid), .result(result), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overflow = the true wide result does not survive truncation to W bits.
  function automatic void sc_model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output logic v);
    longint sx, sy, t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    v = 1'b0;
    case (op)
      4'd0, 4'd8: begin t = sx + sy; r = t[31:0]; v = (t != longint'($signed(r))); end
      4'd7:       begin t = sx - sy; r = t[31:0]; v = (t != longint'($signed(r))); end
      4'd1:       r = x & y;
      4'd4:       r = ~(x | y);
      4'd5:       r = x | y;
      4'd6:       r = (sx < sy) ? 32'd1 : 32'd0;
      default:    r = '0;
    endcase
  endfunction

  function automatic void md_model(input logic is_div, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mz);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mz = 1'b0;
    if (!is_div) begin
      p = sx * sy;
      mh = p[63:32];
      ml = p[31:0];
    end else if (y == '0) begin
      ml = '1;
      mh = x;
      mz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      mh = r[31:0];
      ml = q[31:0];
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; alucon = 4'd0; a = '0; b = '0;
    tick(); tick();
    total++;
    if ({busy, in_ready, out_valid, result, zero, overflow, div_by_zero, hi, lo} !==
        {1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset: busy=%b rdy=%b ov=%b res=%h z=%b o=%b dz=%b hi=%h lo=%h, want all 0 except rdy=1",
               busy, in_ready, out_valid, result, zero, overflow, div_by_zero, hi, lo);
    end
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    tick();
  endtask

  task automatic test_stream();
    logic [3:0]   ops [4] = '{4'd0, 4'd7, 4'd6, 4'd4};
    logic [W-1:0] xa  [4] = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] xb  [4] = '{32'd5, 32'd7, 32'd1, 32'd0};
    logic [W-1:0] xr  [4] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alucon = ops[i]; a = xa[i]; b = xb[i];
      tick();
      total++;
      if ({out_valid, result, zero, overflow} !== {1'b1, xr[i], 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stream[%0d]: ov=%b res=%h z=%b o=%b, want ov=1 res=%h z=0 o=0",
                 i, out_valid, result, zero, overflow, xr[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, result, zero} !== {1'b0, 32'hFFFF_FFFF, 1'b0}) begin
      bad++;
      $display("FAIL stream_hold: ov=%b res=%h z=%b, want ov=0 res=ffffffff z=0", out_valid, result, zero);
    end
  endtask

  task automatic test_overflow();
    logic [3:0]   ops [4] = '{4'd0, 4'd7, 4'd8, 4'd1};
    logic [W-1:0] xa  [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] xb  [4] = '{32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] xr  [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
    logic         xo  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alucon = ops[i]; a = xa[i]; b = xb[i];
      tick();
      total++;
      if ({out_valid, result, zero, overflow} !== {1'b1, xr[i], xr[i] == 32'h0, xo[i]}) begin
        bad++;
        $display("FAIL overflow[%0d]: ov=%b res=%h z=%b o=%b, want res=%h o=%b",
                 i, out_valid, result, zero, overflow, xr[i], xo[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, overflow} !== 2'b00) begin
      bad++;
      $display("FAIL flag_hold: ov=%b o=%b, want 0 0 (last op was and)", out_valid, overflow);
    end
  endtask

  task automatic test_unrecognised();
    for (int op = 9; op < 16; op++) begin
      in_valid = 1'b1; alucon = 4'(op); a = $urandom | 32'h1; b = $urandom;
      tick();
      total++;
      if ({out_valid, result, zero, overflow, div_by_zero} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL unrecognised op=%0d: ov=%b res=%h z=%b o=%b, want 1 0 1 0",
                 op, out_valid, result, zero, overflow);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_single();
    logic [3:0]   op;
    logic [W-1:0] er;
    logic         eo;
    logic [W-1:0] corner [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd2 || op == 4'd3) op = 4'd0;
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      in_valid = 1'b1; alucon = op;
      sc_model(op, a, b, er, eo);
      tick();
      total++;
      if ({out_valid, result, zero, overflow, div_by_zero, hi, lo} !==
          {1'b1, er, er == 32'h0, eo, 1'b0, exp_hi, exp_lo}) begin
        bad++;
        $display("FAIL random_single[%0d] op=%0d: ov=%b res=%h z=%b o=%b dz=%b hi=%h lo=%h, want res=%h o=%b hi=%h lo=%h",
                 i, op, out_valid, result, zero, overflow, div_by_zero, hi, lo, er, eo, exp_hi, exp_lo);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic run_md(input logic is_div, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic         ez;
    int           got, busy_cnt;
    logic         held_ok;
    md_model(is_div, x, y, eh, el, ez);
    in_valid = 1'b1; alucon = is_div ? 4'd2 : 4'd3; a = x; b = y;
    tick();
    got = 0; busy_cnt = 0; held_ok = 1'b1;
    for (int k = 1; k <= 60 && got == 0; k++) begin
      if (out_valid) begin
        got = k;
      end else begin
        if (busy && !in_ready) busy_cnt++;
        if (hi !== exp_hi || lo !== exp_lo) held_ok = 1'b0;
        if (busy) begin
          in_valid = 1'($urandom_range(0, 1));
          alucon   = 4'($urandom_range(0, 15));
          a = $urandom; b = $urandom;
        end else begin
          in_valid = 1'b0;
        end
        tick();
      end
    end
    in_valid = 1'b0;
    total++;
    if (got != 34 || busy_cnt != 33) begin
      bad++;
      $display("FAIL md_latency %h %s %h: out_valid at cycle %0d busy %0d cycles, want 34 and 33",
               x, is_div ? "div" : "mul", y, got, busy_cnt);
    end
    total++;
    if (!held_ok) begin
      bad++;
      $display("FAIL md_hilo_hold %h/%h: hi/lo changed while busy, want %h %h", x, y, exp_hi, exp_lo);
    end
    total++;
    if ({busy, result, zero, overflow, div_by_zero, hi, lo} !== {1'b0, el, el == 32'h0, 1'b0, ez, eh, el}) begin
      bad++;
      $display("FAIL md_result %h %s %h: busy=%b res=%h z=%b o=%b dz=%b hi=%h lo=%h, want res=%h dz=%b hi=%h lo=%h",
               x, is_div ? "div" : "mul", y, busy, result, zero, overflow, div_by_zero, hi, lo, el, ez, eh, el);
    end
    exp_hi = eh;
    exp_lo = el;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL md_pulse: out_valid=%b one cycle after done, want 0", out_valid);
    end
  endtask

  task automatic test_mul();
    run_md(1'b0, 32'hFFFF_FFFD, 32'd7);
  endtask

  task automatic test_div();
    run_md(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_md(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(1'b1, 32'd9, 32'd0);
  endtask

  task automatic test_random_md();
    logic [W-1:0] y;
    for (int i = 0; i < 16; i++) begin
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) y = -y;
      run_md(1'($urandom_range(0, 1)), $urandom, y);
    end
  endtask

  task automatic test_flush();
    int stray;
    logic [3:0] ops [2] = '{4'd3, 4'd2};
    int         at  [2] = '{10, 33};
    run_md(1'b0, 32'h8765_4321, 32'h1234_5678);
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1; alucon = ops[t]; a = $urandom; b = $urandom | 32'h1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k < at[t]; k++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++;
      if ({busy, in_ready, out_valid, hi, lo} !== {1'b0, 1'b1, 1'b0, exp_hi, exp_lo}) begin
        bad++;
        $display("FAIL flush_cycle%0d: busy=%b rdy=%b ov=%b hi=%h lo=%h, want 0 1 0 hi=%h lo=%h",
                 at[t], busy, in_ready, out_valid, hi, lo, exp_hi, exp_lo);
      end
      stray = 0;
      for (int k = 0; k < 40; k++) begin
        if (out_valid || busy) stray++;
        tick();
      end
      total++;
      if (stray != 0) begin
        bad++;
        $display("FAIL flush_quiet%0d: %0d cycles with out_valid/busy after flush, want 0", at[t], stray);
      end
    end
    in_valid = 1'b1; alucon = 4'd0; a = 32'd1; b = 32'd1; flush = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_same_cycle_add: out_valid=%b, want 0", out_valid);
    end
    alucon = 4'd3;
    tick();
    total++;
    if ({busy, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL flush_same_cycle_mul: busy=%b ov=%b, want 0 0", busy, out_valid);
    end
    in_valid = 1'b0; flush = 1'b0;
    tick();
    run_md(1'b1, 32'hFFFF_FF00, 32'd7);
  endtask

  task automatic test_reset_mid_div();
    int stray;
    in_valid = 1'b1; alucon = 4'd0; a = 32'h7FFF_FFFF; b = 32'd1;
    tick();
    alucon = 4'd2; a = 32'd1000; b = 32'd3;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, out_valid, result, zero, overflow, div_by_zero, hi, lo} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_mid_div: busy=%b ov=%b res=%h z=%b o=%b dz=%b hi=%h lo=%h, want all 0",
               busy, out_valid, result, zero, overflow, div_by_zero, hi, lo);
    end
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid || busy) stray++;
      tick();
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL reset_quiet: %0d cycles with out_valid/busy after reset, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_unrecognised();
    test_random_single();
    test_mul();
    test_div();
    test_random_md();
    test_flush();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
